// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit engine among four requesters.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed priority (req0 highest) instead of round-robin.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic              tx_rdy,
    output logic              writes0,
    output logic [7:0]        tb_in,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            writes0_q, writes0_d;
    logic [7:0]      tb_in_q, tb_in_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      owner_q, owner_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [1:0]      win_idx;

`ifdef UART_TX_ARB_FIXED_PRI_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
            end
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    // Search starts one past the last granted requester so it becomes lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_q + 2'(i) + 2'd1;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        writes0_d = 1'b0;
        gnt_d     = '0;
        tb_in_d   = tb_in_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
`ifndef UART_TX_ARB_FIXED_PRI_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Strobe and grant are registered here so they appear together in ISSUE.
                if (tx_rdy && win_found) begin
                    tb_in_d        = req_data[win_idx*8 +: 8];
                    owner_d        = win_idx;
                    busy_d         = 1'b1;
                    writes0_d      = 1'b1;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
`ifndef UART_TX_ARB_FIXED_PRI_EN
                ptr_d   = owner_q;
`endif
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_rdy) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_rdy) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            writes0_q <= 1'b0;
            gnt_q     <= '0;
            tb_in_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRI_EN
            ptr_q     <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            writes0_q <= writes0_d;
            gnt_q     <= gnt_d;
            tb_in_q   <= tb_in_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
`ifndef UART_TX_ARB_FIXED_PRI_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign writes0 = writes0_q;
    assign tb_in   = tb_in_q;
    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmit-engine model driving tx_rdy.
module tb_uart_tx_arbiter;

    localparam int FRAME = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_rdy = 1'b1;
    logic        writes0;
    logic [7:0]  tb_in;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter #(.NREQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .tx_rdy   (tx_rdy),
        .writes0  (writes0),
        .tb_in    (tb_in),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: loads on a sampled writes0, stays busy for FRAME cycles.
    int   eng_cnt  = 0;
    logic eng_hold = 1'b0;
    logic w_s;
    always @(posedge clk) begin
        w_s = writes0;
        #1;
        if (rst)            eng_cnt = 0;
        else if (w_s)       eng_cnt = FRAME;
        else if (eng_cnt > 0) eng_cnt--;
        tx_rdy = (eng_cnt == 0) && !eng_hold;
    end

    int cyc     = 0;
    int n_w0    = 0;
    int last_w0 = -1000;
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) last_w0 = -1000;
        if (writes0) begin
            n_w0++;
            check("w0_while_rdy", 32'(tx_rdy), 1);
            if (last_w0 >= 0) check("w0_gap_min", 32'((cyc - last_w0) >= FRAME + 3), 1);
            last_w0 = cyc;
        end
        if (gnt != 4'b0000) check("gnt_with_w0", 32'(writes0), 1);
    end

    task automatic wait_gnt(input string tag, output logic [3:0] g);
        bit seen = 1'b0;
        g = '0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                @(posedge clk);
                #3;
                if (gnt != 4'b0000) begin
                    g    = gnt;
                    seen = 1'b1;
                end
            end
        end
        check({tag, "_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!done) begin
                @(posedge clk);
                #3;
                if (!busy && tx_rdy) done = 1'b1;
            end
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    logic [1:0] ord [5];
    logic [7:0] bytes [4];
    logic [3:0] g;
    int         base;
    int         c0;

    initial begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
        ord = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        bytes = '{8'h10, 8'h21, 8'h32, 8'h43};

        rst = 1'b1; req = 4'b0000; req_data = '0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_writes0", 32'(writes0), 0);
        check("rst_gnt",     32'(gnt),     0);
        check("rst_tb_in",   32'(tb_in),   0);
        check("rst_owner",   32'(owner),   0);
        check("rst_busy",    32'(busy),    0);

        // single request
        rst = 1'b0;
        base = n_w0;
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        wait_gnt("t1", g);
        check("t1_gnt",  32'(g),       32'h1);
        check("t1_byte", 32'(tb_in),   32'hA5);
        check("t1_w0",   32'(writes0), 1);
        check("t1_busy", 32'(busy),    1);
        req = 4'b0000;
        @(posedge clk); #3;
        check("t1_w0_once", 32'(writes0), 0);
        check("t1_busy_hold", 32'(busy), 1);
        wait_idle("t1");
        repeat (12) @(posedge clk);
        #3;
        check("t1_frames", 32'(n_w0 - base), 1);

        // all four requesting
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        req_data = 32'h4332_2110;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("t2", g);
            check($sformatf("t2_gnt%0d", k),  32'(g),     32'(4'b0001 << ord[k]));
            check($sformatf("t2_byte%0d", k), 32'(tb_in), 32'(bytes[ord[k]]));
            req = req & ~g;
            @(posedge clk); #3;
            req = 4'b1111;
        end
        req = 4'b0000;
        wait_idle("t2");

        // request while engine busy
        eng_hold = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        base = n_w0;
        req_data = 32'h005C_0000;
        req = 4'b0100;
        repeat (6) @(posedge clk);
        #3;
        check("t3_no_w0", 32'(n_w0 - base), 0);
        eng_hold = 1'b0;
        @(posedge clk); #3;
        check("t3_w0_early", 32'(writes0), 0);
        @(posedge clk); #3;
        check("t3_w0",   32'(writes0), 1);
        check("t3_gnt",  32'(gnt),     32'h4);
        check("t3_byte", 32'(tb_in),   32'h5C);
        req = 4'b0000;
        wait_idle("t3");

        // one-cycle request, gone during ISSUE
        base = n_w0;
        req_data = 32'h0000_7E00;
        req = 4'b0010;
        @(posedge clk); #3;
        req = 4'b0000;
        check("t4_w0",   32'(writes0), 1);
        check("t4_gnt",  32'(gnt),     32'h2);
        check("t4_byte", 32'(tb_in),   32'h7E);
        wait_idle("t4");
        repeat (12) @(posedge clk);
        #3;
        check("t4_frames", 32'(n_w0 - base), 1);

        // reset during WAIT_HI
        req_data = 32'hC300_0000;
        req = 4'b1000;
        wait_gnt("t5", g);
        check("t5_gnt", 32'(g), 32'h8);
        req = 4'b0000;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk); #3;
        check("t5_rst_writes0", 32'(writes0), 0);
        check("t5_rst_gnt",     32'(gnt),     0);
        check("t5_rst_tb_in",   32'(tb_in),   0);
        check("t5_rst_owner",   32'(owner),   0);
        check("t5_rst_busy",    32'(busy),    0);
        rst = 1'b0;
        req_data = 32'h4332_2110;
        req = 4'b1111;
        wait_gnt("t5b", g);
        check("t5_first_gnt",  32'(g),     32'h1);
        check("t5_first_byte", 32'(tb_in), 32'h10);
        req = 4'b0000;
        wait_idle("t5");

        // back-to-back on requester 3
        req_data = 32'h9900_0000;
        req = 4'b1000;
        wait_gnt("t6a", g);
        check("t6_gnt_a", 32'(g), 32'h8);
        c0 = cyc;
        wait_gnt("t6b", g);
        check("t6_gnt_b", 32'(g), 32'h8);
        check("t6_gap_b", 32'(cyc - c0), 32'(FRAME + 3));
        c0 = cyc;
        wait_gnt("t6c", g);
        check("t6_gap_c", 32'(cyc - c0), 32'(FRAME + 3));
        req = 4'b0000;
        wait_idle("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
